// File: rtl/full_st1_tap_src.sv
// Tap-word stream source for full_st1: a host-loaded register bank is streamed over the
// vld/fst/rdy handshake for a programmed length and number of passes.
module full_st1_tap_src #(
  parameter int DEPTH  = 24,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [3:0]        passes,
  output logic [31:0]       tap_in,
  output logic              tap_in_fst,
  output logic              tap_in_vld,
  input  logic              tap_in_rdy,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1'b1);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1'b1);

  logic [31:0]       bank_r [DEPTH];
  state_t            state_r, state_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic [3:0]        pass_r, pass_s;
  logic [ADDR_W:0]   len_r, len_s;
  logic [3:0]        passes_r, passes_s;
  logic [31:0]       tap_r, tap_s;
  logic              fst_r, fst_s;
  logic              vld_r, vld_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              wr_err_r, wr_err_s;

  logic              xfer_s;
  logic              last_word_s;
  logic              last_pass_s;
  logic              start_ok_s;
  logic [ADDR_W-1:0] idx_inc_s;

  assign xfer_s      = vld_r & tap_in_rdy;
  assign last_word_s = ({1'b0, idx_r} == (len_r - LEN_ONE));
  assign last_pass_s = (pass_r == (passes_r - 4'd1));
  assign start_ok_s  = (len != {(ADDR_W+1){1'b0}}) && (len <= DEPTH_L) && (passes != 4'd0);
  assign idx_inc_s   = idx_r + IDX_ONE;

  // Host write port; the bank is deliberately left out of reset so taps survive it.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_r && ({1'b0, wr_addr} < DEPTH_L)) begin
      bank_r[wr_addr] <= wr_data;
    end
  end

  // Next-state and next-output logic; the output word is fetched with the next index so
  // back-to-back transfers need no bubble.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    pass_s   = pass_r;
    len_s    = len_r;
    passes_s = passes_r;
    tap_s    = tap_r;
    fst_s    = fst_r;
    vld_s    = vld_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    wr_err_s = wr_err_r | (wr_en & busy_r);
    case (state_r)
      IDLE: begin
        if (start && start_ok_s) begin
          state_s  = SEND;
          len_s    = len;
          passes_s = passes;
          idx_s    = {ADDR_W{1'b0}};
          pass_s   = 4'd0;
          tap_s    = bank_r[{ADDR_W{1'b0}}];
          fst_s    = 1'b1;
          vld_s    = 1'b1;
          busy_s   = 1'b1;
          wr_err_s = 1'b0;
        end else if (start) begin
          done_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && last_word_s && last_pass_s) begin
          state_s = IDLE;
          vld_s   = 1'b0;
          fst_s   = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else if (xfer_s && last_word_s) begin
          idx_s  = {ADDR_W{1'b0}};
          pass_s = pass_r + 4'd1;
          tap_s  = bank_r[{ADDR_W{1'b0}}];
          fst_s  = 1'b1;
        end else if (xfer_s) begin
          idx_s = idx_inc_s;
          tap_s = bank_r[idx_inc_s];
          fst_s = 1'b0;
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
        vld_s   = 1'b0;
        fst_s   = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      idx_r    <= {ADDR_W{1'b0}};
      pass_r   <= 4'd0;
      len_r    <= {(ADDR_W+1){1'b0}};
      passes_r <= 4'd0;
      tap_r    <= 32'd0;
      fst_r    <= 1'b0;
      vld_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      wr_err_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      pass_r   <= pass_s;
      len_r    <= len_s;
      passes_r <= passes_s;
      tap_r    <= tap_s;
      fst_r    <= fst_s;
      vld_r    <= vld_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      wr_err_r <= wr_err_s;
    end
  end

  assign tap_in     = tap_r;
  assign tap_in_fst = fst_r;
  assign tap_in_vld = vld_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign wr_err     = wr_err_r;

endmodule

// File: tb/tb_full_st1_tap_src.sv
// Bench for full_st1_tap_src: directed sequence plus randomized ready/stream parameters,
// checked against a queue-of-expected-beats model built from the bank contents.
module tb_full_st1_tap_src;

  typedef struct {
    logic [31:0] data;
    logic        fst;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic        start = 1'b0;
  logic [5:0]  len = 6'd0;
  logic [3:0]  passes = 4'd0;
  logic [31:0] tap_in;
  logic        tap_in_fst;
  logic        tap_in_vld;
  logic        tap_in_rdy = 1'b0;
  logic        busy;
  logic        done;
  logic        wr_err;

  logic [31:0] bank_m [24];
  logic        exp_wr_err = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  full_st1_tap_src #(.DEPTH(24), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .passes(passes), .tap_in(tap_in), .tap_in_fst(tap_in_fst),
    .tap_in_vld(tap_in_vld), .tap_in_rdy(tap_in_rdy), .busy(busy), .done(done),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle_vld", tap_in_vld, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_wr_err", wr_err, exp_wr_err);
    end
  endtask

  task automatic host_write(input int addr, input logic [31:0] data);
    wr_en = 1'b1;
    wr_addr = 5'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (addr < 24) bank_m[addr] = data;
    chk("wr_err_idle_write", wr_err, exp_wr_err);
  endtask

  task automatic illegal_start(input int ln, input int ps);
    start = 1'b1;
    len = 6'(ln);
    passes = 4'(ps);
    tick();
    start = 1'b0;
    chk("illegal_done", done, 1'b1);
    chk("illegal_vld", tap_in_vld, 1'b0);
    chk("illegal_busy", busy, 1'b0);
    chk("illegal_wr_err", wr_err, exp_wr_err);
  endtask

  // Streams ln words for ps passes; ends on the cycle where done is expected.
  task automatic stream(input int ln, input int ps, input int rdy_pct,
                        input bit wr_busy, input bit start_busy);
    word_t q[$];
    int beats = 0;
    int budget = ln * ps * 40 + 50;
    bit wr_done = 1'b0;
    bit sb_done = 1'b0;
    for (int p = 0; p < ps; p++)
      for (int i = 0; i < ln; i++) q.push_back('{bank_m[i], (i == 0)});
    start = 1'b1;
    len = 6'(ln);
    passes = 4'(ps);
    tap_in_rdy = ($urandom_range(99) < rdy_pct);
    tick();
    start = 1'b0;
    exp_wr_err = 1'b0;
    while (q.size() > 0 && budget > 0) begin
      chk("vld", tap_in_vld, 1'b1);
      chk("data", tap_in, q[0].data);
      chk("fst", tap_in_fst, q[0].fst);
      chk("busy", busy, 1'b1);
      chk("done_early", done, 1'b0);
      chk("wr_err", wr_err, exp_wr_err);
      tap_in_rdy = ($urandom_range(99) < rdy_pct);
      wr_en = 1'b0;
      start = 1'b0;
      if (wr_busy && !wr_done && beats == 2) begin
        wr_en = 1'b1;
        wr_addr = 5'd0;
        wr_data = ~bank_m[0];
        wr_done = 1'b1;
      end
      if (start_busy && !sb_done && beats == 1) begin
        start = 1'b1;
        len = 6'd1;
        passes = 4'd1;
        sb_done = 1'b1;
      end
      tick();
      if (wr_en) exp_wr_err = 1'b1;
      if (tap_in_rdy) begin
        void'(q.pop_front());
        beats++;
      end
      budget--;
    end
    wr_en = 1'b0;
    start = 1'b0;
    if (q.size() != 0) chk("stream_timeout", q.size(), 0);
    chk("end_done", done, 1'b1);
    chk("end_vld", tap_in_vld, 1'b0);
    chk("end_fst", tap_in_fst, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("end_wr_err", wr_err, exp_wr_err);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_vld", tap_in_vld, 1'b0);
    chk("rst_fst", tap_in_fst, 1'b0);
    chk("rst_tap", tap_in, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    tick();
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 24; i++) host_write(i, 32'h3F80_0000 + 32'(i));
    host_write(24, 32'hDEAD_0024);
    host_write(31, 32'hDEAD_0031);

    stream(24, 1, 100, 1'b0, 1'b0);
    idle(1);
    stream(4, 1, 50, 1'b0, 1'b0);
    idle(1);
    stream(3, 2, 100, 1'b0, 1'b0);
    idle(1);
    illegal_start(0, 1);
    illegal_start(25, 1);
    illegal_start(3, 0);
    idle(1);
    stream(6, 1, 100, 1'b0, 1'b1);
    idle(1);
    stream(5, 1, 70, 1'b1, 1'b0);
    illegal_start(0, 2);
    idle(2);
    stream(2, 1, 100, 1'b0, 1'b0);
    stream(3, 1, 100, 1'b0, 1'b0);
    idle(1);

    start = 1'b1;
    len = 6'd8;
    passes = 4'd1;
    tap_in_rdy = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_data", tap_in, bank_m[4]);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_vld", tap_in_vld, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_fst", tap_in_fst, 1'b0);
    chk("mid_rst_tap", tap_in, 32'd0);
    exp_wr_err = 1'b0;
    tick();
    reset = 1'b0;
    idle(1);
    stream(2, 1, 100, 1'b0, 1'b0);
    idle(1);

    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 3; w++) host_write($urandom_range(31), $urandom);
      stream($urandom_range(24, 1), $urandom_range(3, 1), $urandom_range(100, 40),
             1'($urandom_range(1)), 1'($urandom_range(1)));
      idle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
